// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared constants, command codes and state type for lcd_ctrl
//
// Holds the image geometry defaults, the starting operation point, the
// 4-bit host command codes and the controller state enum.
package lcd_ctrl_pkg;

    localparam int IMG_W   = 8;
    localparam int PIX_W   = 8;
    localparam int INIT_PT = 4;
    localparam int CMD_W   = 4;

    localparam logic [CMD_W-1:0] CMD_WRITE = 4'd0;
    localparam logic [CMD_W-1:0] CMD_UP    = 4'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 4'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 4'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 4'd4;
    localparam logic [CMD_W-1:0] CMD_MAX   = 4'd5;
    localparam logic [CMD_W-1:0] CMD_MIN   = 4'd6;
    localparam logic [CMD_W-1:0] CMD_AVG   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_CCW   = 4'd8;
    localparam logic [CMD_W-1:0] CMD_CW    = 4'd9;
    localparam logic [CMD_W-1:0] CMD_MIRX  = 4'd10;
    localparam logic [CMD_W-1:0] CMD_MIRY  = 4'd11;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// rtl/lcd_win_alu.sv - combinational 2x2 window operator for lcd_ctrl
//
// Ports:
//   cmd_i        command code (only 5..11 modify the window)
//   p0_i..p3_i   current window, P0 P1 / P2 P3
//   p0_o..p3_o   new window contents
//   we_o         1 when the command rewrites the window
//
// Optional build macro LCD_CTRL_AVG_ROUND_EN: Average rounds half-up
// ((sum+2)>>2, clamped to the pixel maximum) instead of truncating.
module lcd_win_alu #(
    parameter int PIX_W = lcd_ctrl_pkg::PIX_W
) (
    input  logic [3:0]       cmd_i,
    input  logic [PIX_W-1:0] p0_i,
    input  logic [PIX_W-1:0] p1_i,
    input  logic [PIX_W-1:0] p2_i,
    input  logic [PIX_W-1:0] p3_i,
    output logic [PIX_W-1:0] p0_o,
    output logic [PIX_W-1:0] p1_o,
    output logic [PIX_W-1:0] p2_o,
    output logic [PIX_W-1:0] p3_o,
    output logic             we_o
);
    import lcd_ctrl_pkg::*;

    // Sum of four pixels needs two extra bits.
    localparam int SW = PIX_W + 2;

    logic [PIX_W-1:0] max01, max23, min01, min23, pmax, pmin, avg;
    logic [SW-1:0]    sum;
`ifdef LCD_CTRL_AVG_ROUND_EN
    logic [SW:0]      sum_r;
    logic [SW:0]      avg_w;
`endif

    always_comb begin
        max01 = (p0_i > p1_i) ? p0_i : p1_i;
        max23 = (p2_i > p3_i) ? p2_i : p3_i;
        pmax  = (max01 > max23) ? max01 : max23;
        min01 = (p0_i < p1_i) ? p0_i : p1_i;
        min23 = (p2_i < p3_i) ? p2_i : p3_i;
        pmin  = (min01 < min23) ? min01 : min23;
        sum   = SW'(p0_i) + SW'(p1_i) + SW'(p2_i) + SW'(p3_i);
`ifdef LCD_CTRL_AVG_ROUND_EN
        sum_r = {1'b0, sum} + (SW+1)'(2);
        avg_w = sum_r >> 2;
        if (avg_w > (SW+1)'({PIX_W{1'b1}})) begin
            avg = '1;
        end else begin
            avg = PIX_W'(avg_w);
        end
`else
        avg   = PIX_W'(sum >> 2);
`endif
    end

    always_comb begin
        p0_o = p0_i;
        p1_o = p1_i;
        p2_o = p2_i;
        p3_o = p3_i;
        we_o = 1'b1;
        case (cmd_i)
            CMD_MAX: begin
                p0_o = pmax; p1_o = pmax; p2_o = pmax; p3_o = pmax;
            end
            CMD_MIN: begin
                p0_o = pmin; p1_o = pmin; p2_o = pmin; p3_o = pmin;
            end
            CMD_AVG: begin
                p0_o = avg; p1_o = avg; p2_o = avg; p3_o = avg;
            end
            CMD_CCW: begin
                p0_o = p1_i; p1_o = p3_i; p2_o = p0_i; p3_o = p2_i;
            end
            CMD_CW: begin
                p0_o = p2_i; p1_o = p0_i; p2_o = p3_i; p3_o = p1_i;
            end
            CMD_MIRX: begin
                p0_o = p2_i; p1_o = p3_i; p2_o = p0_i; p3_o = p1_i;
            end
            CMD_MIRY: begin
                p0_o = p1_i; p1_o = p0_i; p2_o = p3_i; p3_o = p2_i;
            end
            default: we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - 8x8 image controller: ROM load, 2x2 window commands, RAM store
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cmd, cmd_valid    host command, accepted when busy=0
//   IROM_rd, IROM_A   image ROM read enable / raster address
//   IROM_Q            ROM data, valid at the rise after the address
//   IRAM_valid/A/D    image RAM write enable / address / data
//   busy              1 while not accepting commands
//   done              1 once the image has been written (sticky)
//
// Optional build macro LCD_CTRL_AVG_ROUND_EN selects rounded Average
// inside lcd_win_alu.
module lcd_ctrl #(
    parameter  int IMG_W  = lcd_ctrl_pkg::IMG_W,
    parameter  int PIX_W  = lcd_ctrl_pkg::PIX_W,
    localparam int ADDR_W = $clog2(IMG_W * IMG_W),
    localparam int CRD_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              IROM_rd,
    output logic [ADDR_W-1:0] IROM_A,
    input  logic [PIX_W-1:0]  IROM_Q,
    output logic              IRAM_valid,
    output logic [PIX_W-1:0]  IRAM_D,
    output logic [ADDR_W-1:0] IRAM_A,
    output logic              busy,
    output logic              done
);
    import lcd_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_W - 1);
    localparam logic [ADDR_W:0]   WR_END    = (ADDR_W+1)'(IMG_W * IMG_W);
    localparam logic [CRD_W-1:0]  PT_MIN    = CRD_W'(1);
    localparam logic [CRD_W-1:0]  PT_MAX    = CRD_W'(IMG_W - 1);
    localparam logic [CRD_W-1:0]  PT_INIT   = CRD_W'(INIT_PT);

    state_e            state_q;
    logic              busy_q, done_q;
    logic              irom_rd_q, iram_valid_q;
    logic [ADDR_W-1:0] irom_a_q, iram_a_q;
    logic [PIX_W-1:0]  iram_d_q;
    logic [CRD_W-1:0]  x_q, y_q, x_d, y_d;
    logic [3:0]        cmd_q;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [PIX_W-1:0]  img_q [IMG_W*IMG_W];

    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic [PIX_W-1:0]  n0, n1, n2, n3;
    logic              alu_we;

    // Window addresses: P3 sits at the operation point, the others are
    // one pixel to the left and/or one row above.
    always_comb begin
        idx3 = ADDR_W'(int'(y_q) * IMG_W + int'(x_q));
        idx2 = idx3 - ADDR_W'(1);
        idx1 = idx3 - ADDR_W'(IMG_W);
        idx0 = idx1 - ADDR_W'(1);
    end

    // Next operation point for shift commands; edges clamp.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (cmd_q)
            CMD_UP:    if (y_q > PT_MIN) y_d = y_q - CRD_W'(1);
            CMD_DOWN:  if (y_q < PT_MAX) y_d = y_q + CRD_W'(1);
            CMD_LEFT:  if (x_q > PT_MIN) x_d = x_q - CRD_W'(1);
            CMD_RIGHT: if (x_q < PT_MAX) x_d = x_q + CRD_W'(1);
            default: ;
        endcase
    end

    lcd_win_alu #(
        .PIX_W (PIX_W)
    ) u_alu (
        .cmd_i (cmd_q),
        .p0_i  (img_q[idx0]),
        .p1_i  (img_q[idx1]),
        .p2_i  (img_q[idx2]),
        .p3_i  (img_q[idx3]),
        .p0_o  (n0),
        .p1_o  (n1),
        .p2_o  (n2),
        .p3_o  (n3),
        .we_o  (alu_we)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            irom_rd_q    <= 1'b0;
            irom_a_q     <= '0;
            iram_valid_q <= 1'b0;
            iram_a_q     <= '0;
            iram_d_q     <= '0;
            x_q          <= PT_INIT;
            y_q          <= PT_INIT;
            cmd_q        <= '0;
            wr_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // First cycle only presents address 0; every later
                    // cycle captures the byte for the previous address.
                    if (irom_rd_q) begin
                        img_q[irom_a_q] <= IROM_Q;
                        if (irom_a_q == LAST_ADDR) begin
                            irom_rd_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            irom_a_q <= irom_a_q + ADDR_W'(1);
                        end
                    end else begin
                        irom_rd_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid && !busy_q) begin
                        cmd_q    <= cmd;
                        busy_q   <= 1'b1;
                        wr_cnt_q <= '0;
                        state_q  <= (cmd == CMD_WRITE) ? S_WRITE : S_EXEC;
                    end
                end
                S_EXEC: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    if (alu_we) begin
                        img_q[idx0] <= n0;
                        img_q[idx1] <= n1;
                        img_q[idx2] <= n2;
                        img_q[idx3] <= n3;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_WRITE: begin
                    if (wr_cnt_q == WR_END) begin
                        iram_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        iram_valid_q <= 1'b1;
                        iram_a_q     <= wr_cnt_q[ADDR_W-1:0];
                        iram_d_q     <= img_q[wr_cnt_q[ADDR_W-1:0]];
                        wr_cnt_q     <= wr_cnt_q + (ADDR_W+1)'(1);
                    end
                end
                S_DONE: begin
                    // Terminal until reset; busy stays high.
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign IROM_rd    = irom_rd_q;
    assign IROM_A     = irom_a_q;
    assign IRAM_valid = iram_valid_q;
    assign IRAM_A     = iram_a_q;
    assign IRAM_D     = iram_d_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q = 8'd0;
    logic       IRAM_valid;
    logic [7:0] IRAM_D;
    logic [5:0] IRAM_A;
    logic       busy;
    logic       done;

    logic [7:0] rom  [64];
    logic [7:0] iram [64];
    logic [7:0] expv [64];

    int n_pass  = 0;
    int n_total = 0;

    initial forever #5 clk = ~clk;

    lcd_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IROM_Q     (IROM_Q),
        .IRAM_valid (IRAM_valid),
        .IRAM_D     (IRAM_D),
        .IRAM_A     (IRAM_A),
        .busy       (busy),
        .done       (done)
    );

    always @(negedge clk) if (IROM_rd === 1'b1) IROM_Q <= rom[IROM_A];
    always @(negedge clk) if (IRAM_valid === 1'b1) iram[IRAM_A] <= IRAM_D;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic rom_ramp();
        for (int i = 0; i < 64; i++) begin
            rom[i]  = 8'(i);
            expv[i] = 8'(i);
        end
    endtask

    task automatic set_win(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        rom[27] = a; rom[28] = b; rom[35] = c; rom[36] = d;
        expv[27] = a; expv[28] = b; expv[35] = c; expv[36] = d;
    endtask

    task automatic load_image(input string tag);
        int  rd_cnt = 0;
        int  cyc = 0;
        bit  addr_ok = 1'b1;
        reset = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        while (busy !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            if (IROM_rd === 1'b1) begin
                if (IROM_A !== 6'(rd_cnt)) addr_ok = 1'b0;
                rd_cnt++;
            end
            cyc++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s load_busy: busy=%b required 0", tag, busy);
        else n_pass++;
        n_total++;
        if (rd_cnt !== 64) $display("FAIL %s load_reads: got %0d required 64", tag, rd_cnt);
        else n_pass++;
        n_total++;
        if (addr_ok !== 1'b1) $display("FAIL %s load_addr_order: got 0 required 1", tag);
        else n_pass++;
    endtask

    task automatic send_exec(input logic [3:0] c, input string tag);
        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s accept_busy: busy=%b required 1", tag, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s exec_release: busy=%b required 0", tag, busy);
        else n_pass++;
    endtask

    task automatic run_write(input string tag);
        int   k = 0;
        int   cyc = 0;
        int   bad = 0;
        int   first_bad = -1;
        bit   order_ok = 1'b1;
        bit   prev63 = 1'b0;
        cmd = 4'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s write_accept: busy=%b required 1", tag, busy);
        else n_pass++;
        while (done !== 1'b1 && cyc < 300) begin
            if (IRAM_valid === 1'b1) begin
                if (IRAM_A !== 6'(k)) order_ok = 1'b0;
                k++;
            end
            prev63 = (IRAM_valid === 1'b1 && IRAM_A === 6'd63);
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL %s done: done=%b required 1", tag, done);
        else n_pass++;
        n_total++;
        if (k !== 64 || order_ok !== 1'b1)
            $display("FAIL %s write_seq: writes=%0d order_ok=%0b required 64/1", tag, k, order_ok);
        else n_pass++;
        n_total++;
        if (prev63 !== 1'b1 || IRAM_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s done_timing: prev63=%0b IRAM_valid=%b busy=%b required 1/0/1",
                     tag, prev63, IRAM_valid, busy);
        else n_pass++;
        for (int i = 0; i < 64; i++) begin
            if (iram[i] !== expv[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_total++;
        if (bad != 0)
            $display("FAIL %s iram_image: %0d bad, addr %0d got %0d required %0d",
                     tag, bad, first_bad, iram[first_bad], expv[first_bad]);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b required 1", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else n_pass++;
        n_total++; if (IRAM_valid !== 1'b0) $display("FAIL rst_iram_valid: got %b required 0", IRAM_valid); else n_pass++;
        n_total++; if (IROM_rd !== 1'b0) $display("FAIL rst_irom_rd: got %b required 0", IROM_rd); else n_pass++;
        n_total++; if (IROM_A !== 6'd0) $display("FAIL rst_irom_a: got %0d required 0", IROM_A); else n_pass++;
        n_total++; if (IRAM_A !== 6'd0) $display("FAIL rst_iram_a: got %0d required 0", IRAM_A); else n_pass++;
        n_total++; if (IRAM_D !== 8'd0) $display("FAIL rst_iram_d: got %0d required 0", IRAM_D); else n_pass++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_total++; if (IROM_rd !== 1'b1) $display("FAIL mid_load_rd: got %b required 1", IROM_rd); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (IROM_A !== 6'd0 || IROM_rd !== 1'b0 || busy !== 1'b1)
            $display("FAIL mid_reset: IROM_A=%0d IROM_rd=%b busy=%b required 0/0/1", IROM_A, IROM_rd, busy);
        else n_pass++;
    endtask

    task automatic test_load_write();
        rom_ramp();
        load_image("ramp");
        run_write("ramp");
        cmd = 4'd5; cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (IRAM_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1)
                $display("FAIL after_done: IRAM_valid=%b done=%b busy=%b required 0/1/1", IRAM_valid, done, busy);
            else n_pass++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_max();
        rom_ramp();
        load_image("max");
        send_exec(4'd5, "max");
        expv[27] = 8'd36; expv[28] = 8'd36; expv[35] = 8'd36; expv[36] = 8'd36;
        run_write("max");
        n_total++; if (iram[27] !== 8'd36) $display("FAIL max_p0: got %0d required 36", iram[27]); else n_pass++;
    endtask

    task automatic test_boundary();
        rom_ramp();
        load_image("bound");
        repeat (4) send_exec(4'd3, "left");
        repeat (4) send_exec(4'd1, "up");
        send_exec(4'd6, "min");
        expv[0] = 8'd0; expv[1] = 8'd0; expv[8] = 8'd0; expv[9] = 8'd0;
        repeat (7) send_exec(4'd4, "right");
        repeat (7) send_exec(4'd2, "down");
        send_exec(4'd5, "max77");
        expv[54] = 8'd63; expv[55] = 8'd63; expv[62] = 8'd63; expv[63] = 8'd63;
        run_write("bound");
        n_total++; if (iram[9] !== 8'd0) $display("FAIL min_corner: got %0d required 0", iram[9]); else n_pass++;
        n_total++; if (iram[54] !== 8'd63) $display("FAIL max_corner: got %0d required 63", iram[54]); else n_pass++;
    endtask

    task automatic test_rotate();
        rom_ramp();
        set_win(8'd10, 8'd20, 8'd30, 8'd40);
        load_image("cw");
        send_exec(4'd9, "cw");
        expv[27] = 8'd30; expv[28] = 8'd10; expv[35] = 8'd40; expv[36] = 8'd20;
        run_write("cw");
        rom_ramp();
        set_win(8'd10, 8'd20, 8'd30, 8'd40);
        load_image("cw_ccw");
        send_exec(4'd9, "cw");
        send_exec(4'd8, "ccw");
        run_write("cw_ccw");
    endtask

    task automatic test_average();
        logic [7:0] avg_exp;
`ifdef LCD_CTRL_AVG_ROUND_EN
        avg_exp = 8'd3;
`else
        avg_exp = 8'd2;
`endif
        rom_ramp();
        set_win(8'd1, 8'd2, 8'd3, 8'd4);
        load_image("avg");
        send_exec(4'd7, "avg");
        expv[27] = avg_exp; expv[28] = avg_exp; expv[35] = avg_exp; expv[36] = avg_exp;
        run_write("avg");
        rom_ramp();
        set_win(8'd255, 8'd255, 8'd255, 8'd255);
        load_image("avg255");
        send_exec(4'd7, "avg255");
        run_write("avg255");
        n_total++; if (iram[36] !== 8'd255) $display("FAIL avg_sat: got %0d required 255", iram[36]); else n_pass++;
    endtask

    task automatic test_handshake();
        logic [3:0] exp_busy;
        exp_busy = 4'b0101;
        rom_ramp();
        load_image("hs");
        cmd = 4'd10; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (busy !== exp_busy[i])
                $display("FAIL hs_busy%0d: got %b required %b", i, busy, exp_busy[i]);
            else n_pass++;
        end
        cmd_valid = 1'b0;
        send_exec(4'd12, "noop");
        run_write("hs");
    endtask

    initial begin
        test_reset();
        test_load_write();
        test_max();
        test_boundary();
        test_rotate();
        test_average();
        test_handshake();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
